// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IF_RESP,
    LS_RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of mem_arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface mem_arbiter_if #(
  parameter int XLEN = 32
) ();

  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [XLEN-1:0] if_rdata;

  logic            ls_req;
  logic            ls_we;
  logic [XLEN-1:0] ls_addr;
  logic [XLEN-1:0] ls_wdata;
  logic [3:0]      ls_be;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [XLEN-1:0] ls_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection; MEM_ARB_RR_EN switches contention from
// fixed load/store priority to round-robin against the last winner.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
  input  logic   mem_ready,
  input  owner_e last_win,
  output logic   issue,
  output owner_e winner
);

  always_comb begin
    issue  = mem_ready & (if_req | ls_req);
    winner = OWN_IF;
    if (ls_req && !if_req) begin
      winner = OWN_LS;
    end else if (ls_req && if_req) begin
`ifdef MEM_ARB_RR_EN
      winner = (last_win == OWN_IF) ? OWN_LS : OWN_IF;
`else
      winner = OWN_LS;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_win;
  assign unused_last_win = last_win;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one single-port memory with 1-cycle
// read latency. Define MEM_ARB_RR_EN for round-robin contention handling.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] conflict_cnt
);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue_raw;
  logic             issue;
  owner_e           winner;
  owner_e           last_win;

`ifdef MEM_ARB_RR_EN
  owner_e last_win_q, last_win_d;
  assign last_win = last_win_q;
`else
  assign last_win = OWN_IF;
`endif

  mem_arb_pick u_pick (
    .if_req    (bus.if_req),
    .ls_req    (bus.ls_req),
    .mem_ready (bus.mem_ready),
    .last_win  (last_win),
    .issue     (issue_raw),
    .winner    (winner)
  );

  always_comb begin
    issue         = issue_raw & ~rst;
    bus.if_gnt    = 1'b0;
    bus.ls_gnt    = 1'b0;
    bus.mem_req   = issue;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    state_d       = IDLE;
    we_d          = we_q;
    if (issue) begin
      if (winner == OWN_LS) begin
        bus.ls_gnt    = 1'b1;
        bus.mem_we    = bus.ls_we;
        bus.mem_addr  = bus.ls_addr;
        bus.mem_wdata = bus.ls_wdata;
        bus.mem_be    = bus.ls_be;
        state_d       = LS_RESP;
        we_d          = bus.ls_we;
      end else begin
        bus.if_gnt    = 1'b1;
        bus.mem_addr  = bus.if_addr;
        bus.mem_be    = BE_ALL;
        state_d       = IF_RESP;
      end
    end

    cnt_d = cnt_q;
    if (bus.if_req && bus.ls_req && bus.mem_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Responses are masked while rst is high so a reset discards an
    // outstanding access in the very cycle it is asserted.
    bus.if_rvalid = (state_q == IF_RESP) & ~rst;
    bus.ls_rvalid = (state_q == LS_RESP) & ~rst;
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.ls_rdata  = (bus.ls_rvalid && !we_q) ? bus.mem_rdata : '0;
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    last_win_d = issue ? winner : last_win_q;
  end
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      cnt_q      <= '0;
`ifdef MEM_ARB_RR_EN
      last_win_q <= OWN_IF;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
`ifdef MEM_ARB_RR_EN
      last_win_q <= last_win_d;
`endif
    end
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grants and commands checked in the issue
// cycle, responses popped from an expectation queue one cycle later.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic       CLK = 1'b0;
  logic       rst;
  logic [3:0] conflict_cnt;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32), .CNT_W(4)) dut (
    .CLK          (CLK),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    owner_e      own;
    logic [31:0] data;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  resp_t       exp_q[$];
  resp_t       mon_r;
  owner_e      last_m = OWN_IF;
  logic [3:0]  exp_cnt = 4'd0;
  logic        mem_lat_req;
  logic [31:0] mem_lat_addr;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: data for the command issued last cycle, junk otherwise.
  always @(posedge CLK) begin
    cyc++;
    mem_lat_req  = bus.mem_req;
    mem_lat_addr = bus.mem_addr;
    #1 bus.mem_rdata = mem_lat_req ? mem_f(mem_lat_addr) : 32'hBAD0_0000;
  end

  // Response monitor: pops the scoreboard when an entry is due.
  always @(negedge CLK) begin
    checks++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_r = exp_q.pop_front();
      if (mon_r.own == OWN_IF) begin
        if ({bus.if_rvalid, bus.if_rdata, bus.ls_rvalid, bus.ls_rdata} !==
            {1'b1, mon_r.data, 1'b0, 32'h0}) begin
          errors++;
          $display("FAIL resp_if cyc=%0d got if_rv=%b if_rd=%h ls_rv=%b ls_rd=%h exp if_rd=%h",
                   cyc, bus.if_rvalid, bus.if_rdata, bus.ls_rvalid, bus.ls_rdata, mon_r.data);
        end
      end else begin
        if ({bus.if_rvalid, bus.if_rdata, bus.ls_rvalid, bus.ls_rdata} !==
            {1'b0, 32'h0, 1'b1, mon_r.data}) begin
          errors++;
          $display("FAIL resp_ls cyc=%0d got if_rv=%b if_rd=%h ls_rv=%b ls_rd=%h exp ls_rd=%h",
                   cyc, bus.if_rvalid, bus.if_rdata, bus.ls_rvalid, bus.ls_rdata, mon_r.data);
        end
      end
    end else begin
      if ({bus.if_rvalid, bus.if_rdata, bus.ls_rvalid, bus.ls_rdata} !== 66'h0) begin
        errors++;
        $display("FAIL resp_none cyc=%0d got if_rv=%b if_rd=%h ls_rv=%b ls_rd=%h exp all 0",
                 cyc, bus.if_rvalid, bus.if_rdata, bus.ls_rvalid, bus.ls_rdata);
      end
    end
  end

  // Drive one cycle of inputs and predict grant, count and response.
  task automatic step_in(input logic ir, input logic [31:0] ia, input logic lr,
                         input logic lwe, input logic [31:0] la, input logic [31:0] lwd,
                         input logic [3:0] lbe, input logic rdy,
                         output logic eg_if, output logic eg_ls);
    owner_e w;
    resp_t  r;
    @(posedge CLK);
    #1;
    bus.if_req = ir; bus.if_addr = ia;
    bus.ls_req = lr; bus.ls_we = lwe; bus.ls_addr = la; bus.ls_wdata = lwd; bus.ls_be = lbe;
    bus.mem_ready = rdy;
    eg_if = 1'b0;
    eg_ls = 1'b0;
    if (ir && lr && rdy && exp_cnt != 4'hF) exp_cnt++;
    if (rdy && (ir || lr)) begin
      if (ir && lr) begin
`ifdef MEM_ARB_RR_EN
        w = (last_m == OWN_IF) ? OWN_LS : OWN_IF;
`else
        w = OWN_LS;
`endif
      end else begin
        w = lr ? OWN_LS : OWN_IF;
      end
      last_m = w;
      r.cyc  = cyc + 1;
      r.own  = w;
      if (w == OWN_LS) begin
        eg_ls  = 1'b1;
        r.data = lwe ? 32'h0 : mem_f(la);
      end else begin
        eg_if  = 1'b1;
        r.data = mem_f(ia);
      end
      exp_q.push_back(r);
    end
  endtask

  task automatic idle();
    logic a, b;
    step_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, b);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    @(posedge CLK);
    #1;
    rst     = 1'b0;
    last_m  = OWN_IF;
    exp_cnt = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h88;
    bus.ls_wdata = 32'hFFFF_FFFF; bus.ls_be = 4'hF; bus.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 72'h0) begin
        errors++;
        $display("FAIL reset_outputs got gnt=%b%b req=%b we=%b addr=%h wd=%h be=%h exp all 0",
                 bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
      end
    end
    @(posedge CLK);
    #1;
    rst = 1'b0;
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    @(negedge CLK);
    checks++;
    if (conflict_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d exp 0", conflict_cnt);
    end
  endtask

  task automatic test_lone_fetch();
    logic eg_if, eg_ls;
    step_in(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, eg_if, eg_ls);
    @(negedge CLK);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !==
        {eg_if, eg_ls, 1'b1, 1'b0, 32'h100, 32'h0, BE_ALL}) begin
      errors++;
      $display("FAIL fetch_cmd got gnt=%b%b req=%b we=%b addr=%h wd=%h be=%h exp gnt=10 addr=100 be=f",
               bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    idle();
  endtask

  task automatic test_lone_load();
    logic eg_if, eg_ls;
    step_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h5555_AAAA, 4'b1000, 1'b1, eg_if, eg_ls);
    @(negedge CLK);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !==
        {eg_if, eg_ls, 1'b1, 1'b0, 32'h40, 32'h5555_AAAA, 4'b1000}) begin
      errors++;
      $display("FAIL load_cmd got gnt=%b%b req=%b we=%b addr=%h wd=%h be=%h exp gnt=01 addr=40",
               bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    idle();
  endtask

  task automatic test_store();
    logic eg_if, eg_ls;
    step_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'b0011, 1'b1, eg_if, eg_ls);
    @(negedge CLK);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !==
        {eg_if, eg_ls, 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'b0011}) begin
      errors++;
      $display("FAIL store_cmd got gnt=%b%b we=%b addr=%h wd=%h be=%h exp we=1 addr=2000 wd=12345678 be=3",
               bus.if_gnt, bus.ls_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    idle();
  endtask

  task automatic test_contention();
    logic eg_if, eg_ls;
`ifdef MEM_ARB_RR_EN
    int n = 4;
`else
    int n = 3;
`endif
    do_reset();
    for (int i = 0; i < n; i++) begin
      step_in(1'b1, 32'h300 + 32'(i * 4), 1'b1, 1'b0, 32'h400 + 32'(i * 4), 32'h0, 4'hF, 1'b1,
              eg_if, eg_ls);
      @(negedge CLK);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt} !== {eg_if, eg_ls}) begin
        errors++;
        $display("FAIL contention_gnt i=%0d got if=%b ls=%b exp if=%b ls=%b",
                 i, bus.if_gnt, bus.ls_gnt, eg_if, eg_ls);
      end
    end
    idle();
    checks++;
    if (conflict_cnt !== 4'(n)) begin
      errors++;
      $display("FAIL contention_cnt got %0d exp %0d", conflict_cnt, n);
    end
  endtask

  task automatic test_back_to_back();
    logic eg_if, eg_ls;
    logic [1:0] pat [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      step_in(pat[i][1], 32'h500 + 32'(i), pat[i][0], 1'b0, 32'h600 + 32'(i), 32'h0, 4'hF, 1'b1,
              eg_if, eg_ls);
      @(negedge CLK);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt, bus.mem_req} !== {eg_if, eg_ls, 1'b1}) begin
        errors++;
        $display("FAIL b2b_gnt i=%0d got if=%b ls=%b req=%b exp if=%b ls=%b req=1",
                 i, bus.if_gnt, bus.ls_gnt, bus.mem_req, eg_if, eg_ls);
      end
    end
    idle();
    checks++;
    if (conflict_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_cnt got %0d exp %0d", conflict_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure_reset();
    logic eg_if, eg_ls;
    step_in(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, eg_if, eg_ls);
    for (int i = 0; i < 2; i++) begin
      step_in(1'b1, 32'h704, 1'b1, 1'b0, 32'h800, 32'h0, 4'hF, 1'b0, eg_if, eg_ls);
      @(negedge CLK);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt, bus.mem_req, conflict_cnt} !== {3'b000, exp_cnt}) begin
        errors++;
        $display("FAIL stall i=%0d got gnt=%b%b req=%b cnt=%0d exp gnt=00 req=0 cnt=%0d",
                 i, bus.if_gnt, bus.ls_gnt, bus.mem_req, conflict_cnt, exp_cnt);
      end
    end
    step_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h800, 32'h0, 4'hF, 1'b1, eg_if, eg_ls);
    void'(exp_q.pop_back());
    @(negedge CLK);
    checks++;
    if (bus.ls_gnt !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_gnt got ls_gnt=%b exp 1", bus.ls_gnt);
    end
    @(posedge CLK);
    #1;
    rst = 1'b1;
    bus.ls_req = 1'b0;
    bus.if_req = 1'b0;
    @(negedge CLK);
    checks++;
    if ({bus.ls_rvalid, bus.if_rvalid, bus.mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL reset_discard got ls_rv=%b if_rv=%b req=%b exp 000",
               bus.ls_rvalid, bus.if_rvalid, bus.mem_req);
    end
    @(posedge CLK);
    #1;
    rst     = 1'b0;
    last_m  = OWN_IF;
    exp_cnt = 4'd0;
    @(negedge CLK);
    checks++;
    if ({bus.ls_rvalid, bus.if_rvalid, conflict_cnt} !== 6'h0) begin
      errors++;
      $display("FAIL post_reset got ls_rv=%b if_rv=%b cnt=%0d exp 0 0 0",
               bus.ls_rvalid, bus.if_rvalid, conflict_cnt);
    end
  endtask

  task automatic test_saturation();
    logic eg_if, eg_ls;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step_in(1'b1, 32'h900 + 32'(i), 1'b1, 1'b0, 32'hA00 + 32'(i), 32'h0, 4'hF, 1'b1,
              eg_if, eg_ls);
      @(negedge CLK);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt} !== {eg_if, eg_ls}) begin
        errors++;
        $display("FAIL sat_gnt i=%0d got if=%b ls=%b exp if=%b ls=%b",
                 i, bus.if_gnt, bus.ls_gnt, eg_if, eg_ls);
      end
    end
    idle();
    checks++;
    if (conflict_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_cnt got %0d exp 15", conflict_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_lone_load();
    test_store();
    test_contention();
    test_back_to_back();
    test_backpressure_reset();
    test_saturation();
    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter CNT_W, default 16, width of the conflict counter.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1 / if_addr  in  XLEN: fetch read request and address.
REQ-006 if_gnt  out  1 / if_rvalid  out  1 / if_rdata  out  XLEN: fetch grant, response valid, read data.
REQ-007 ls_req  in  1 / ls_we  in  1 / ls_addr  in  XLEN / ls_wdata  in  XLEN / ls_be  in  4: load/store request.
REQ-008 ls_gnt  out  1 / ls_rvalid  out  1 / ls_rdata  out  XLEN: load/store grant, response or write-ack, read data.
REQ-009 mem_req  out  1 / mem_we  out  1 / mem_addr  out  XLEN / mem_wdata  out  XLEN / mem_be  out  4: shared single-port memory command.
REQ-010 mem_ready  in  1 / mem_rdata  in  XLEN: memory accepts a command this cycle; read data valid the cycle after issue.
REQ-011 conflict_cnt  out  CNT_W: saturating count of cycles in which both requesters asked and one was refused.

Function
REQ-012 An access is issued in a cycle only when mem_ready=1 and at least one req=1; mem_req is high exactly in issue cycles.
REQ-013 Exactly one of if_gnt/ls_gnt is high in an issue cycle, both low otherwise; grant is combinational, same cycle as issue.
REQ-014 Single requester: that requester wins.
REQ-015 Both requesting, default build: ls wins (fixed priority); the if requester holds if_req/if_addr until granted.
REQ-016 mem_addr/mem_we/mem_wdata/mem_be come from the winner; an if issue drives mem_we=0, mem_be=4'b1111, mem_wdata=0; all command outputs are 0 when mem_req=0.
REQ-017 FSM states IDLE, IF_RESP, LS_RESP; next state = IF_RESP if if issued, LS_RESP if ls issued, else IDLE; evaluated in every state.
REQ-018 Sustained throughput is one access per cycle; a new issue in the same cycle as a response is permitted.
REQ-019 if_rvalid=1 iff state=IF_RESP; ls_rvalid=1 iff state=LS_RESP; read latency is exactly 1 cycle after grant.
REQ-020 if_rdata/ls_rdata = mem_rdata when the matching rvalid=1, else 0; a store response (ls_we was 1) gives ls_rvalid=1 with ls_rdata=0.
REQ-021 A registered we-flag records ls_we of the issued ls access to select rdata zeroing in REQ-020.
REQ-022 conflict_cnt increments by 1 in any cycle with if_req=1, ls_req=1, mem_ready=1; holds at 2^CNT_W-1.
REQ-023 mem_ready=0 with requests pending: no grant, no count increment, pending response (if any) still delivered.

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE, we-flag=0, last-winner=IF, conflict_cnt=0.
REQ-025 During rst=1 all grants, mem_req and command outputs are 0.
REQ-026 Reset with an access outstanding discards its response: no rvalid in the following cycle.

Configuration
REQ-027 Macro MEM_ARB_RR_EN defined: contention resolved round-robin; winner is the requester that was not the last-winner; last-winner updates on every issue.
REQ-028 MEM_ARB_RR_EN undefined: fixed ls-over-if priority per REQ-015; last-winner register is not present.

Structure
REQ-029 Package mem_arb_pkg holds the state enum (IDLE, IF_RESP, LS_RESP), the owner encoding (OWN_IF, OWN_LS) and constant BE_ALL=4'b1111.
REQ-030 Winner selection is a combinational sub-module mem_arb_pick (inputs if_req, ls_req, mem_ready, last-winner; outputs issue, winner); all registers stay in mem_arbiter.

Verification
REQ-031 Lone fetch: if_req=1, if_addr=0x100, mem_rdata=0xDEADBEEF next cycle -> if_gnt=1 cycle 0, if_rvalid=1 with if_rdata=0xDEADBEEF cycle 1.
REQ-032 Contention, default build: both req for 3 cycles -> ls_gnt cycles 0-2, if_gnt 0, conflict_cnt=3.
REQ-033 Contention, MEM_ARB_RR_EN: both req for 4 cycles from reset -> grants ls, if, ls, if; rvalids follow one cycle later in same order.
REQ-034 Store: ls_we=1, ls_addr=0x2000, ls_wdata=0x12345678, ls_be=4'b0011 -> mem_we=1 with those values, next cycle ls_rvalid=1, ls_rdata=0.
REQ-035 Backpressure and reset: mem_ready=0 for 2 cycles -> no grants, count unchanged; then grant with rst=1 next cycle -> no rvalid, conflict_cnt=0.
REQ-036 Saturation with CNT_W=4: 20 contention cycles -> conflict_cnt=15.
